pjdl_receive_mc: RTL

Parametrised next-generation PJDL receiver. Decodes the single-wire PJDL bit stream into words and streams them out over AXI-Stream with `tlast` marking the end of a frame. Over the previous receiver it adds:
- configurable word width, counter width and FIFO depth;
- explicit framing-error, overflow and acknowledge-timeout reporting;
- optional majority-vote bit sampling.

It sits between the PJON pin and the Layer-3 / wrapper AXI-Stream sink, alongside the PJDL transmitter.

---
 rtl/pjdl_receive_mc.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pjdl_receive_mc.sv
// pjdl_receive_mc: PJDL single-wire receiver that decodes the line into words
// and streams them out over AXI-Stream, with tlast marking the end of a frame.
// Optional build macro PJDL_RX_MAJORITY_EN selects 2-of-3 majority bit
// sampling; when it is undefined each bit is a single sample at the end of
// the bit period.

package pjdl_receive_mc_pkg;

    // Default AXI-Stream request carrying one 8-bit word per beat.
    typedef struct packed {
        logic [7:0] tdata;
        logic [0:0] tstrb;
        logic [0:0] tkeep;
        logic       tlast;
        logic [0:0] tid;
        logic [0:0] tdest;
        logic [0:0] tuser;
        logic       tvalid;
    } axis_req_t;

    // Default AXI-Stream response: only the sink ready.
    typedef struct packed {
        logic tready;
    } axis_rsp_t;

endpackage

module pjdl_receive_mc #(
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned CntWidth   = 20,
    parameter int unsigned BufferSize = 4,
    parameter type axis_req_t = pjdl_receive_mc_pkg::axis_req_t,
    parameter type axis_rsp_t = pjdl_receive_mc_pkg::axis_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                pjon_i,
    input  logic                start_ack_receiving_i,
    input  logic                clear_i,
    input  logic [CntWidth-1:0] pjdl_spec_data_i,
    input  logic [CntWidth-1:0] pjdl_spec_pad_i,
    input  logic [CntWidth-1:0] pjdl_spec_acceptance_i,
    input  logic [CntWidth-1:0] ack_timeout_i,
    input  axis_rsp_t           axis_write_rsp_i,
    output axis_req_t           axis_write_req_o,
    output logic                receiving_in_progress_o,
    output logic                framing_error_o,
    output logic                overflow_o,
    output logic                ack_timeout_o
);

    localparam int unsigned BitW   = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam int unsigned PtrW   = (BufferSize > 1) ? $clog2(BufferSize) : 1;
    localparam int unsigned CountW = $clog2(BufferSize + 1);

    typedef enum logic [2:0] {
        IDLE,
        ACK_WAIT,
        SYNC,
        DATA,
        HOLD
    } state_e;

    state_e                 state_q, state_d;
    logic                   pjon_q, last_q;
    logic [CntWidth-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                   sync_low_q, sync_low_d;
    logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DataWidth-1:0]   sr_q, sr_d;
    logic                   bit_sample;
    logic                   rising, falling;
    logic [CntWidth-1:0]    half_period;

    logic                   push_d, push_last_d;
    logic                   push_valid_q, push_last_q;
    logic [DataWidth-1:0]   push_data_q;
    logic                   framing_error_d, framing_error_q;
    logic                   ack_timeout_d, ack_timeout_q;
    logic                   overflow_q;

    logic [DataWidth:0]     mem_q [BufferSize];
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0]      fifo_count_q;
    logic                   fifo_full, fifo_empty;
    logic                   pop, push_accept, push_drop;

    assign rising      = pjon_q & ~last_q;
    assign falling     = ~pjon_q & last_q;
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CntWidth'(1);
    assign half_period = pjdl_spec_data_i >> 1;

`ifdef PJDL_RX_MAJORITY_EN
    logic [1:0] vote_q;

    // Capture the two early votes of each bit; the third is the live sample.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vote_q <= '0;
        end else if (state_q == DATA) begin
            if (cnt_q == pjdl_spec_data_i - CntWidth'(3)) vote_q[0] <= pjon_q;
            if (cnt_q == pjdl_spec_data_i - CntWidth'(2)) vote_q[1] <= pjon_q;
        end
    end

    assign bit_sample = (vote_q[0] & vote_q[1]) | (vote_q[0] & pjon_q) | (vote_q[1] & pjon_q);
`else
    assign bit_sample = pjon_q;
`endif

    // Decoder state, line synchroniser and status pulse registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            pjon_q          <= 1'b0;
            last_q          <= 1'b0;
            cnt_q           <= '0;
            sync_low_q      <= 1'b0;
            bit_cnt_q       <= '0;
            sr_q            <= '0;
            push_valid_q    <= 1'b0;
            push_last_q     <= 1'b0;
            push_data_q     <= '0;
            framing_error_q <= 1'b0;
            ack_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            pjon_q          <= pjon_i;
            last_q          <= pjon_q;
            cnt_q           <= cnt_d;
            sync_low_q      <= sync_low_d;
            bit_cnt_q       <= bit_cnt_d;
            sr_q            <= sr_d;
            push_valid_q    <= push_d;
            push_last_q     <= push_last_d;
            if (push_d) push_data_q <= sr_q;
            framing_error_q <= framing_error_d;
            ack_timeout_q   <= ack_timeout_d;
        end
    end

    // Next-state decoding of sync pad, data bits and end-of-word hold.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        sync_low_d      = sync_low_q;
        bit_cnt_d       = bit_cnt_q;
        sr_d            = sr_q;
        push_d          = 1'b0;
        push_last_d     = 1'b0;
        framing_error_d = 1'b0;
        ack_timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                sync_low_d = 1'b0;
                if (start_ack_receiving_i) begin
                    state_d = ACK_WAIT;
                end else if (rising && enable_i) begin
                    state_d = SYNC;
                end
            end

            ACK_WAIT: begin
                cnt_d = cnt_inc;
                if (pjon_q) begin
                    state_d    = SYNC;
                    cnt_d      = '0;
                    sync_low_d = 1'b0;
                end else if (cnt_q == ack_timeout_i) begin
                    ack_timeout_d = 1'b1;
                    state_d       = IDLE;
                    cnt_d         = '0;
                end
            end

            SYNC: begin
                cnt_d = cnt_inc;
                if (!sync_low_q) begin
                    if (falling) begin
                        if (cnt_q < pjdl_spec_acceptance_i) begin
                            framing_error_d = 1'b1;
                            state_d         = IDLE;
                            cnt_d           = '0;
                            sr_d            = '0;
                        end else begin
                            cnt_d      = CntWidth'(1);
                            sync_low_d = 1'b1;
                        end
                    end
                end else if (cnt_inc >= half_period) begin
                    state_d    = DATA;
                    cnt_d      = '0;
                    bit_cnt_d  = '0;
                    sync_low_d = 1'b0;
                end
            end

            DATA: begin
                cnt_d = cnt_inc;
                if (cnt_q == pjdl_spec_data_i - CntWidth'(1)) begin
                    cnt_d     = '0;
                    sr_d      = {bit_sample, sr_q[DataWidth-1:1]};
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == BitW'(DataWidth - 1)) begin
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                if (rising) begin
                    push_d      = 1'b1;
                    push_last_d = 1'b0;
                    state_d     = SYNC;
                    cnt_d       = '0;
                    sync_low_d  = 1'b0;
                end else if (!pjon_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= pjdl_spec_pad_i) begin
                        push_d      = 1'b1;
                        push_last_d = 1'b1;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Dropping enable abandons any frame in flight; ack waiting is kept.
        if (!enable_i && (state_q == SYNC || state_q == DATA || state_q == HOLD)) begin
            state_d         = IDLE;
            cnt_d           = '0;
            sync_low_d      = 1'b0;
            sr_d            = '0;
            push_d          = 1'b0;
            push_last_d     = 1'b0;
            framing_error_d = 1'b0;
        end
    end

    assign fifo_full   = (fifo_count_q == CountW'(BufferSize));
    assign fifo_empty  = (fifo_count_q == '0);
    assign pop         = !fifo_empty && axis_write_rsp_i.tready;
    assign push_accept = push_valid_q && (!fifo_full || pop);
    assign push_drop   = push_valid_q && fifo_full && !pop;

    // FIFO storage; contents need no reset because occupancy gates them.
    always_ff @(posedge clk_i) begin
        if (push_accept) mem_q[wr_ptr_q] <= {push_last_q, push_data_q};
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(BufferSize - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(BufferSize - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (push_accept && !pop) begin
                fifo_count_q <= fifo_count_q + CountW'(1);
            end else if (pop && !push_accept) begin
                fifo_count_q <= fifo_count_q - CountW'(1);
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
            end else if (clear_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Present the FIFO head as an AXI-Stream beat with fixed side fields.
    always_comb begin
        axis_write_req_o                        = '0;
        axis_write_req_o.tdata[DataWidth-1:0]   = mem_q[rd_ptr_q][DataWidth-1:0];
        axis_write_req_o.tlast                  = mem_q[rd_ptr_q][DataWidth];
        axis_write_req_o.tstrb                  = '1;
        axis_write_req_o.tkeep                  = '1;
        axis_write_req_o.tvalid                 = !fifo_empty;
    end

    assign receiving_in_progress_o = (state_q != IDLE);
    assign framing_error_o         = framing_error_q;
    assign ack_timeout_o           = ack_timeout_q;
    assign overflow_o              = overflow_q;

endmodule
